// File: rtl/ahb_lite_master_pkg.sv
// AHB-Lite encodings and shared types for the AHB-Lite initiator.
// Imported by the initiator top and its lane-steering helper.
package ahb_lite_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_B = 3'd0;
  localparam logic [2:0] HSIZE_H = 3'd1;
  localparam logic [2:0] HSIZE_W = 3'd2;
  localparam logic [2:0] HSIZE_D = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_ERR,
    ST_REPLAY
  } state_t;

  // Dword transfers only exist on a 64-bit bus.
  function automatic logic size_legal(
    input logic [2:0] size,
    input int         xlen
  );
    if (xlen == 64) return size <= HSIZE_D;
    return size <= HSIZE_W;
  endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane steering between right-justified command data and the AHB bus.
// Write data is shifted up to its lane; read data is shifted down and masked.
module ahb_lane_align
  import ahb_lite_master_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OW   = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] wdata,
  input  logic [OW-1:0]   waddr_lo,
  output logic [XLEN-1:0] wdata_lane,
  input  logic [XLEN-1:0] rdata,
  input  logic [OW-1:0]   raddr_lo,
  input  logic [2:0]      rsize,
  output logic [XLEN-1:0] rdata_lane
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;

  assign wdata_lane = wdata << {waddr_lo, 3'b000};
  assign shifted    = rdata >> {raddr_lo, 3'b000};

  // Keep only the 8<<size low bits; a full-width access keeps everything.
  always_comb begin
    mask = '1;
    if (int'(rsize) < OW)
      mask = (XLEN'(1) << (8 << rsize)) - XLEN'(1);
    rdata_lane = shifted & mask;
  end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: cmd/rsp front end to pipelined single NONSEQ transfers.
// Handles wait states, two-cycle ERROR with replay, and local misalign errors.
module ahb_lite_master
  import ahb_lite_master_pkg::*;
#(
  parameter int   XLEN    = 64,
  parameter logic HPROT_P = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic            cmd_insn,
  input  logic [2:0]      cmd_size,
  input  logic [XLEN-1:0] cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [1:0]      htrans,
  output logic [XLEN-1:0] haddr,
  output logic            hwrite,
  output logic [2:0]      hsize,
  output logic [2:0]      hburst,
  output logic [3:0]      hprot,
  output logic            hmastlock,
  output logic [XLEN-1:0] hwdata,
  input  logic [XLEN-1:0] hrdata,
  input  logic            hready,
  input  logic            hresp
);

  localparam int OW = $clog2(XLEN / 8);

  state_t state, state_nxt;

  logic            ap_valid;
  logic [XLEN-1:0] ap_wdata;

  logic            rp_valid;
  logic [XLEN-1:0] rp_addr;
  logic            rp_write;
  logic [2:0]      rp_size;
  logic [3:0]      rp_prot;
  logic [XLEN-1:0] rp_wdata;

  logic            dp_valid;
  logic            dp_write;
  logic [2:0]      dp_size;
  logic [OW-1:0]   dp_lo;

  logic            lcl_err;

  logic [OW-1:0]   amask;
  logic            cmd_bad;
  logic            accept;
  logic            load_cmd;
  logic            load_rp;
  logic            err_start;
  logic            in_err;
  logic            ap_done;
  logic            dp_done;
  logic [XLEN-1:0] wdata_lane;
  logic [XLEN-1:0] rdata_lane;

  // Low address bits that must be zero for the requested size.
  always_comb begin
    amask = '0;
    for (int i = 0; i < OW; i++)
      amask[i] = (i < int'(cmd_size));
  end

  assign cmd_bad = !size_legal(cmd_size, XLEN)
                 | (|(cmd_addr[OW-1:0] & amask));

  // Local errors bypass the bus, so they wait for an empty pipe to keep order.
  assign cmd_ready = (state == ST_RUN)
                   & (!ap_valid | hready)
                   & !reset
                   & !lcl_err
                   & (!cmd_bad | (!ap_valid & !dp_valid));

  assign accept    = cmd_valid & cmd_ready;
  assign load_cmd  = accept & !cmd_bad;
  assign in_err    = (state == ST_ERR);
  assign err_start = (state == ST_RUN) & dp_valid
                   & (hresp == HRESP_ERROR) & !hready;
  assign load_rp   = in_err & hready & rp_valid;
  assign ap_done   = ap_valid & hready;
  assign dp_done   = dp_valid & hready;

  assign hburst    = HBURST_SINGLE;
  assign hmastlock = 1'b0;

  ahb_lane_align #(
    .XLEN (XLEN),
    .OW   (OW)
  ) u_align (
    .wdata      (ap_wdata),
    .waddr_lo   (haddr[OW-1:0]),
    .wdata_lane (wdata_lane),
    .rdata      (hrdata),
    .raddr_lo   (dp_lo),
    .rsize      (dp_size),
    .rdata_lane (rdata_lane)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // FSM next state: error entry, error completion, one-cycle replay issue.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:    if (err_start) state_nxt = ST_ERR;
      ST_ERR:    if (hready) state_nxt = rp_valid ? ST_REPLAY : ST_RUN;
      ST_REPLAY: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Address phase: new command, replayed transfer, or retire/cancel to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      ap_valid <= 1'b0;
      htrans   <= HTRANS_IDLE;
      haddr    <= '0;
      hwrite   <= 1'b0;
      hsize    <= 3'd0;
      hprot    <= 4'd0;
      ap_wdata <= '0;
    end else if (load_cmd) begin
      ap_valid <= 1'b1;
      htrans   <= HTRANS_NONSEQ;
      haddr    <= cmd_addr;
      hwrite   <= cmd_write;
      hsize    <= cmd_size;
      hprot    <= {2'b00, HPROT_P, !cmd_insn};
      ap_wdata <= cmd_wdata;
    end else if (load_rp) begin
      ap_valid <= 1'b1;
      htrans   <= HTRANS_NONSEQ;
      haddr    <= rp_addr;
      hwrite   <= rp_write;
      hsize    <= rp_size;
      hprot    <= rp_prot;
      ap_wdata <= rp_wdata;
    end else if (ap_done | err_start) begin
      ap_valid <= 1'b0;
      htrans   <= HTRANS_IDLE;
    end
  end

  // Replay holder: parks the address phase cancelled by an ERROR.
  always_ff @(posedge clock) begin
    if (reset) begin
      rp_valid <= 1'b0;
      rp_addr  <= '0;
      rp_write <= 1'b0;
      rp_size  <= 3'd0;
      rp_prot  <= 4'd0;
      rp_wdata <= '0;
    end else if (err_start & ap_valid) begin
      rp_valid <= 1'b1;
      rp_addr  <= haddr;
      rp_write <= hwrite;
      rp_size  <= hsize;
      rp_prot  <= hprot;
      rp_wdata <= ap_wdata;
    end else if (load_rp) begin
      rp_valid <= 1'b0;
    end
  end

  // Data phase: take over the completed address phase, drive lane-steered hwdata.
  always_ff @(posedge clock) begin
    if (reset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_size  <= 3'd0;
      dp_lo    <= '0;
      hwdata   <= '0;
    end else if (ap_done) begin
      dp_valid <= 1'b1;
      dp_write <= hwrite;
      dp_size  <= hsize;
      dp_lo    <= haddr[OW-1:0];
      if (hwrite) hwdata <= wdata_lane;
    end else if (dp_done) begin
      dp_valid <= 1'b0;
    end
  end

  // Response register: bus completions and local misalign/size errors.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      lcl_err   <= 1'b0;
    end else begin
      rsp_valid <= dp_done | lcl_err;
      rsp_err   <= lcl_err
                 | (dp_done & ((hresp == HRESP_ERROR) | in_err));
      rsp_rdata <= (dp_done & !dp_write & (hresp == HRESP_OKAY) & !in_err)
                 ? rdata_lane : '0;
      lcl_err   <= accept & cmd_bad;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master against a scripted AHB responder.
// The responder adds wait states and two-cycle ERRORs on request.
module tb_ahb_lite_master;
  import ahb_lite_master_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic        cmd_insn = 1'b0;
  logic [2:0]  cmd_size = 3'd0;
  logic [63:0] cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [63:0] rsp_rdata;
  logic [1:0]  htrans;
  logic [63:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [63:0] hwdata;
  logic [63:0] hrdata;
  logic        hready;
  logic        hresp;

  always #5 clock = ~clock;

  ahb_lite_master #(
    .XLEN    (64),
    .HPROT_P (1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_insn  (cmd_insn),
    .cmd_size  (cmd_size),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .htrans    (htrans),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hprot     (hprot),
    .hmastlock (hmastlock),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  logic [63:0] mem [0:1023];
  int          waits = 0;
  logic        err_en = 1'b0;
  logic [63:0] err_addr = '0;

  logic        s_act;
  logic [63:0] s_addr;
  logic        s_wr;
  int          s_wcnt;
  logic        s_err;
  logic        s_eph;
  logic [63:0] last_wdata;

  assign hready = !s_act || (s_wcnt == 0 && (!s_err || s_eph));
  assign hresp  = s_act && s_wcnt == 0 && s_err;
  assign hrdata = (s_act && !s_wr) ? mem[s_addr[12:3]] : 64'd0;

  always @(posedge clock) begin
    if (reset) begin
      s_act      <= 1'b0;
      s_addr     <= '0;
      s_wr       <= 1'b0;
      s_wcnt     <= 0;
      s_err      <= 1'b0;
      s_eph      <= 1'b0;
      last_wdata <= '0;
    end else begin
      if (s_act && s_wcnt != 0) s_wcnt <= s_wcnt - 1;
      else if (s_act && s_err && !s_eph) s_eph <= 1'b1;
      if (hready) begin
        if (s_act && s_wr && !s_err) last_wdata <= hwdata;
        s_act  <= (htrans == HTRANS_NONSEQ);
        s_addr <= haddr;
        s_wr   <= hwrite;
        s_wcnt <= waits;
        s_err  <= err_en && (haddr == err_addr);
        s_eph  <= 1'b0;
      end
    end
  end

  logic [64:0] rq[$];
  logic [63:0] aq[$];
  int          hold_viol = 0;
  logic [1:0]  err2_htrans = 2'b11;
  logic [63:0] err1_addr = '1;
  logic        prev_ns = 1'b0;
  logic        prev_rdy = 1'b1;
  logic [63:0] prev_addr = '0;

  always @(negedge clock) begin
    if (!reset) begin
      if (rsp_valid) rq.push_back({rsp_err, rsp_rdata});
      if (htrans == HTRANS_NONSEQ && hready) aq.push_back(haddr);
      if (htrans == HTRANS_NONSEQ && prev_ns && !prev_rdy && haddr != prev_addr)
        hold_viol++;
      if (hresp && !hready) err1_addr = haddr;
      if (hresp && hready) err2_htrans = htrans;
      prev_ns   = (htrans == HTRANS_NONSEQ);
      prev_rdy  = hready;
      prev_addr = haddr;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic w, input logic ins, input logic [2:0] sz,
                      input logic [63:0] a, input logic [63:0] d);
    int n;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_insn  = ins;
    cmd_size  = sz;
    cmd_addr  = a;
    cmd_wdata = d;
    #1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("cmd_accept", 64'(cmd_ready), 64'd1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int k);
    int n;
    n = 0;
    while (rq.size() < k && n < 100) begin
      step();
      n++;
    end
    chk("rsp_count", 64'(rq.size()), 64'(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int rb;
    int ab;
    int hv;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 6; i++) mem[i] = 64'hA5A5_0000_0000_0000 + 64'(i * 17 + 3);
    mem[512] = 64'h1122_3344_5566_7788;

    cmd_valid = 1'b1;
    cmd_size  = HSIZE_D;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_htrans", 64'(htrans), 64'(HTRANS_IDLE));
      chk("rst_ready", 64'(cmd_ready), 64'd0);
      chk("rst_rsp", 64'(rsp_valid), 64'd0);
    end
    chk("rst_haddr", haddr, 64'd0);
    chk("rst_hwdata", hwdata, 64'd0);
    chk("rst_hprot", 64'(hprot), 64'd0);
    chk("rst_hburst", 64'(hburst), 64'(HBURST_SINGLE));
    cmd_valid = 1'b0;
    reset = 1'b0;
    step();

    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_insn  = 1'b0;
    cmd_size  = HSIZE_W;
    cmd_addr  = 64'h14;
    cmd_wdata = 64'hDEAD_BEEF;
    #1;
    chk("wr_ready", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    chk("wr_htrans", 64'(htrans), 64'(HTRANS_NONSEQ));
    chk("wr_haddr", haddr, 64'h14);
    chk("wr_hsize", 64'(hsize), 64'd2);
    chk("wr_hwrite", 64'(hwrite), 64'd1);
    chk("wr_hprot", 64'(hprot), 64'h3);
    step();
    chk("wr_hwdata", hwdata, 64'hDEAD_BEEF_0000_0000);
    chk("wr_idle", 64'(htrans), 64'(HTRANS_IDLE));
    chk("wr_rsp_early", 64'(rsp_valid), 64'd0);
    step();
    chk("wr_rsp", 64'(rsp_valid), 64'd1);
    chk("wr_rsp_err", 64'(rsp_err), 64'd0);
    chk("wr_mem", last_wdata, 64'hDEAD_BEEF_0000_0000);
    step();
    step();

    rb = rq.size();
    send(1'b0, 1'b1, HSIZE_B, 64'h1005, 64'd0);
    wait_rsp(rb + 1);
    chk("rb_err", 64'(rq[rb][64]), 64'd0);
    chk("rb_data", rq[rb][63:0], 64'h33);
    step();
    step();

    waits = 2;
    rb = rq.size();
    ab = aq.size();
    hv = hold_viol;
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0, HSIZE_D, 64'(i * 8), 64'd0);
    wait_rsp(rb + 4);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_addr", aq[ab + i], 64'(i * 8));
      chk("b2b_err", 64'(rq[rb + i][64]), 64'd0);
      chk("b2b_data", rq[rb + i][63:0], 64'hA5A5_0000_0000_0000 + 64'(i * 17 + 3));
    end
    chk("b2b_hold", 64'(hold_viol - hv), 64'd0);
    waits = 0;
    step();
    step();

    err_en   = 1'b1;
    err_addr = 64'h20;
    rb = rq.size();
    ab = aq.size();
    send(1'b0, 1'b0, HSIZE_D, 64'h20, 64'd0);
    send(1'b0, 1'b0, HSIZE_D, 64'h28, 64'd0);
    wait_rsp(rb + 2);
    chk("er_held", err1_addr, 64'h28);
    chk("er_idle", 64'(err2_htrans), 64'(HTRANS_IDLE));
    chk("er_rsp0_err", 64'(rq[rb][64]), 64'd1);
    chk("er_rsp0_data", rq[rb][63:0], 64'd0);
    chk("er_rsp1_err", 64'(rq[rb + 1][64]), 64'd0);
    chk("er_rsp1_data", rq[rb + 1][63:0], 64'hA5A5_0000_0000_0058);
    chk("er_nseq_cnt", 64'(aq.size() - ab), 64'd2);
    chk("er_replay", aq[ab + 1], 64'h28);
    err_en = 1'b0;
    step();
    step();

    ab = aq.size();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_size  = HSIZE_H;
    cmd_addr  = 64'h3;
    #1;
    chk("ma_ready", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    chk("ma_htrans", 64'(htrans), 64'(HTRANS_IDLE));
    chk("ma_busy", 64'(cmd_ready), 64'd0);
    chk("ma_rsp_early", 64'(rsp_valid), 64'd0);
    step();
    chk("ma_rsp", 64'(rsp_valid), 64'd1);
    chk("ma_rsp_err", 64'(rsp_err), 64'd1);
    chk("ma_ready2", 64'(cmd_ready), 64'd1);
    chk("ma_no_bus", 64'(aq.size() - ab), 64'd0);
    step();

    rb = rq.size();
    send(1'b0, 1'b0, 3'd4, 64'h0, 64'd0);
    wait_rsp(rb + 1);
    chk("sz_err", 64'(rq[rb][64]), 64'd1);
    chk("sz_no_bus", 64'(aq.size() - ab), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
